// File: rtl/xbus_seq_pkg.sv
// Shared definitions for the XSOC bus sequencer: ctrl bit positions,
// region field location, FSM state encoding and a ctrl packing helper.
package xbus_seq_pkg;

  localparam int CTRL_ADDR_LSB = 0;
  localparam int CTRL_ADDR_MSB = 4;
  localparam int CTRL_RD       = 5;
  localparam int CTRL_WUD      = 6;
  localparam int CTRL_WLD      = 7;
  localparam int CTRL_STB      = 8;

  localparam int REGION_LSB = 12;
  localparam int REGION_MSB = 15;

  localparam int WS_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DATA = 2'd3
  } seq_state_t;

  // Builds the abstract ctrl word; unused upper bits stay zero.
  function automatic logic [15:0] pack_ctrl(input logic [4:0] a,
                                            input logic       rd,
                                            input logic       wud,
                                            input logic       wld,
                                            input logic       stb);
    logic [15:0] c;
    c = '0;
    c[CTRL_ADDR_MSB:CTRL_ADDR_LSB] = a;
    c[CTRL_RD]  = rd;
    c[CTRL_WUD] = wud;
    c[CTRL_WLD] = wld;
    c[CTRL_STB] = stb;
    return c;
  endfunction

endpackage

// File: rtl/xbus_seq_if.sv
// CPU-side request/response channel of the bus sequencer.
interface xbus_seq_if;

  logic        req;
  logic        we;
  logic        word;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rdy;
  logic [15:0] rdata;
  logic        err;

  modport master (
    output req, we, word, addr, wdata,
    input  rdy, rdata, err
  );

  modport slave (
    input  req, we, word, addr, wdata,
    output rdy, rdata, err
  );

endinterface

// File: rtl/xbus_lane.sv
// Big-endian byte-lane steering: write enables per lane, write-data
// replication for byte writes and zero-extension of byte reads.
// Purely combinational so it can be reused by other bus masters.
module xbus_lane (
  input  logic        word,
  input  logic        lane_lo,
  input  logic [15:0] wdata,
  input  logic [15:0] d_in,
  output logic        wud,
  output logic        wld,
  output logic [15:0] d_out,
  output logic [15:0] rdata
);

  // Even byte address lives on the upper lane, odd on the lower lane.
  always_comb begin
    wud   = word || !lane_lo;
    wld   = word || lane_lo;
    d_out = word ? wdata : {wdata[7:0], wdata[7:0]};
    if (word) begin
      rdata = d_in;
    end else if (lane_lo) begin
      rdata = {8'h00, d_in[7:0]};
    end else begin
      rdata = {8'h00, d_in[15:8]};
    end
  end

endmodule

// File: rtl/xbus_seq.sv
// XSOC bus sequencer: turns one CPU request into ctrl/sel/d bus cycles
// with per-region wait states, big-endian lane steering and an error
// response for unmapped regions. All bus-facing outputs are registered.
module xbus_seq
  import xbus_seq_pkg::*;
#(
  parameter int NSEL   = 4,
  parameter int WS_RAM = 0,
  parameter int WS_EXT = 2
) (
  input  logic            clk,
  input  logic            rst,
  xbus_seq_if.slave       bus,
  output logic [15:0]     ctrl,
  output logic [NSEL-1:0] sel,
  inout  wire  [15:0]     d
);

  seq_state_t state, next_state;
  logic [WS_W-1:0] cnt, next_cnt, ws_load;

  logic        lat_we, lat_word, lat_mapped;
  logic [3:0]  lat_region;
  logic [4:0]  lat_addr;
  logic [15:0] lat_wdata;

  logic        acc_we, acc_word, acc_mapped;
  logic [3:0]  acc_region;
  logic [4:0]  acc_addr;
  logic [15:0] acc_wdata;

  logic [3:0]  in_region;
  logic        in_mapped;

  logic        lane_wud, lane_wld;
  logic [15:0] lane_dout, lane_rdata;

  logic [15:0]     ctrl_nx;
  logic [NSEL-1:0] sel_nx;
  logic            drive_nx, rdy_nx, err_nx;
  logic            drive_q, rdy_q, err_q;
  logic [15:0]     rdata_q;

  logic unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[11:5];

  assign in_region = bus.addr[REGION_MSB:REGION_LSB];
  assign in_mapped = (32'(in_region) < NSEL);
  assign ws_load   = (in_mapped && in_region == 4'd0) ? WS_W'(WS_RAM) : WS_W'(WS_EXT);

  assign bus.rdy   = rdy_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  assign d = drive_q ? lane_dout : 16'hzzzz;

  // In IDLE the outputs for the upcoming ADDR cycle come straight from the
  // request; in every other state they come from the latched copy.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_we     = bus.we;
      acc_word   = bus.word;
      acc_addr   = bus.addr[4:0];
      acc_wdata  = bus.wdata;
      acc_region = in_region;
      acc_mapped = in_mapped;
    end else begin
      acc_we     = lat_we;
      acc_word   = lat_word;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
      acc_region = lat_region;
      acc_mapped = lat_mapped;
    end
  end

  xbus_lane u_lane (
    .word    (acc_word),
    .lane_lo (acc_addr[0]),
    .wdata   (acc_wdata),
    .d_in    (d),
    .wud     (lane_wud),
    .wld     (lane_wld),
    .d_out   (lane_dout),
    .rdata   (lane_rdata)
  );

  // Next-state and wait-counter logic; the counter never wraps below zero.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          next_state = ST_ADDR;
          next_cnt   = ws_load;
        end
      end
      ST_ADDR: begin
        next_state = (cnt != '0) ? ST_WAIT : ST_DATA;
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          next_cnt = cnt - 1'b1;
        end
        if (cnt <= WS_W'(1)) begin
          next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so they register on the same edge.
  always_comb begin
    ctrl_nx  = '0;
    sel_nx   = '0;
    drive_nx = 1'b0;
    rdy_nx   = 1'b0;
    err_nx   = 1'b0;
    if (next_state != ST_IDLE) begin
      ctrl_nx = pack_ctrl(acc_addr,
                          acc_mapped && !acc_we,
                          (next_state == ST_DATA) && acc_mapped && acc_we && lane_wud,
                          (next_state == ST_DATA) && acc_mapped && acc_we && lane_wld,
                          (next_state == ST_DATA) && acc_mapped);
      for (int i = 0; i < NSEL; i++) begin
        sel_nx[i] = acc_mapped && (32'(acc_region) == i);
      end
      drive_nx = acc_mapped && acc_we;
      if (next_state == ST_DATA) begin
        rdy_nx = 1'b1;
        err_nx = !acc_mapped;
      end
    end
  end

  // State, counter and registered bus outputs; reset drops everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ctrl    <= '0;
      sel     <= '0;
      drive_q <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      ctrl    <= ctrl_nx;
      sel     <= sel_nx;
      drive_q <= drive_nx;
      rdy_q   <= rdy_nx;
      err_q   <= err_nx;
    end
  end

  // Capture the request fields when an access is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_word   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_region <= '0;
      lat_mapped <= 1'b0;
    end else if (state == ST_IDLE && bus.req) begin
      lat_we     <= bus.we;
      lat_word   <= bus.word;
      lat_addr   <= bus.addr[4:0];
      lat_wdata  <= bus.wdata;
      lat_region <= in_region;
      lat_mapped <= in_mapped;
    end
  end

  // Sample the slave's data at the end of the last ADDR/WAIT cycle so it is valid with rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (next_state == ST_DATA) begin
      rdata_q <= (acc_mapped && !acc_we) ? lane_rdata : 16'h0000;
    end
  end

endmodule
